seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 137 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - configurable serial pattern detector with run control
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cfg_valid / cfg_ready       configuration handshake (accepted only in IDLE)
//   cfg_pattern, cfg_len        pattern (bit cfg_len-1 arrives first) and length
//   cfg_threshold               hit count that ends a run, 0 = free-run
//   start, stop                 arm / disarm pulses
//   a                           serial data, one bit per clock while armed
//   detected                    registered one-cycle match pulse
//   hit_count                   matches counted in the current/last run
//   busy, done                  state flags for ARMED and DONE
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_threshold,
    input  logic               start,
    input  logic               stop,
    input  logic               a,
    output logic               detected,
    output logic [CNT_W-1:0]   hit_count,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [MAX_LEN-1:0] ONES    = '1;
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);

    logic [1:0]         state;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic [CNT_W-1:0]   thr_r;
    // Only MAX_LEN-1 past bits are kept; the current bit completes the window.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_next;
    logic [CNT_W-1:0]   hit_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               match;

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_ARMED);
    assign done      = (state == S_DONE);

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        window    = {hist, a};
        // len_r is always within 1..MAX_LEN, so the shift keeps exactly len_r ones.
        mask      = ONES >> (LEN_MAX - len_r);
        fill_inc  = {1'b0, fill} + (LEN_W+1)'(1);
        fill_next = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
        hit_inc   = (hit_count == '1) ? hit_count : hit_count + CNT_W'(1);
        match     = (fill_inc >= {1'b0, len_r}) && (((window ^ pat_r) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pat_r     <= '0;
            len_r     <= LEN_MAX;
            thr_r     <= '0;
            hist      <= '0;
            fill      <= '0;
            hit_count <= '0;
            detected  <= 1'b0;
        end else begin
            detected <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        pat_r <= cfg_pattern;
                        len_r <= len_clamped;
                        thr_r <= cfg_threshold;
                    end
                    if (start) begin
                        state     <= S_ARMED;
                        hist      <= '0;
                        fill      <= '0;
                        hit_count <= '0;
                    end
                end
                S_ARMED: begin
                    // stop discards the bit sampled on the same edge, even a matching one.
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        hist <= window[MAX_LEN-2:0];
                        fill <= fill_next;
                        if (match) begin
                            detected  <= 1'b1;
                            hit_count <= hit_inc;
                            if ((thr_r != '0) && (hit_inc == thr_r)) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        state     <= S_ARMED;
                        hist      <= '0;
                        fill      <= '0;
                        hit_count <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic [7:0] cfg_threshold = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       a = 1'b0;
    logic       detected;
    logic [7:0] hit_count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    seq_detect_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_threshold(cfg_threshold),
        .start(start), .stop(stop), .a(a),
        .detected(detected), .hit_count(hit_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic bit_v, input logic stop_v, input logic start_v);
        a = bit_v; stop = stop_v; start = start_v;
        @(posedge clk); #1;
        a = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic [7:0] thr, input logic with_start);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_threshold = thr;
        start = with_start;
        @(posedge clk); #1;
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL reset_detected got %b exp 0", detected); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL reset_hit_count got %0d exp 0", hit_count); end
        rst = 1'b0;
    endtask

    task automatic test_free_run;
        logic [9:0] seq = 10'b1100110011;
        do_cfg(8'b00110011, 4'd6, 8'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL free_busy_armed got %b exp 1", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL free_cfg_ready got %b exp 0", cfg_ready); end
        for (int i = 0; i < 10; i++) begin
            // a start pulse during ARMED must not restart the run
            step(seq[9-i], 1'b0, (i == 6));
            checks++;
            if (detected !== ((i == 5) || (i == 9))) begin
                errors++; $display("FAIL free_detected bit %0d got %b exp %b", i + 1, detected, ((i == 5) || (i == 9)));
            end
        end
        checks++; if (hit_count !== 8'd2) begin errors++; $display("FAIL free_hit_count got %0d exp 2", hit_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL free_busy_end got %b exp 1", busy); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL free_stop_idle got %b exp 1", cfg_ready); end
        checks++; if (hit_count !== 8'd2) begin errors++; $display("FAIL free_stop_hold got %0d exp 2", hit_count); end
    endtask

    task automatic test_threshold;
        logic [5:0] seq = 6'b101010;
        logic [3:0] tail = 4'b1010;
        do_cfg(8'b00001010, 4'd4, 8'd2, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(seq[5-i], 1'b0, 1'b0);
            checks++;
            if (detected !== ((i == 3) || (i == 5))) begin
                errors++; $display("FAIL thr_detected bit %0d got %b exp %b", i + 1, detected, ((i == 3) || (i == 5)));
            end
            checks++;
            if (done !== (i == 5)) begin
                errors++; $display("FAIL thr_done bit %0d got %b exp %b", i + 1, done, (i == 5));
            end
        end
        // cfg_valid in DONE must wait; it is held until IDLE
        cfg_valid = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_threshold = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step(tail[3-i], 1'b0, 1'b0);
            checks++; if (detected !== 1'b0) begin errors++; $display("FAIL done_ignore_a got %b exp 0", detected); end
        end
        checks++; if (hit_count !== 8'd2) begin errors++; $display("FAIL done_hit_hold got %0d exp 2", hit_count); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL done_cfg_ready got %b exp 0", cfg_ready); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_stays got %b exp 1", done); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_restart_busy got %b exp 1", busy); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL done_restart_clear got %0d exp 0", hit_count); end
        step(1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
    endtask

    task automatic test_stop_race;
        do_cfg(8'b00001010, 4'd4, 8'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL race_detected got %b exp 0", detected); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL race_idle got %b exp 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_busy got %b exp 0", busy); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL race_hit_count got %0d exp 0", hit_count); end
    endtask

    task automatic test_cfg_with_start;
        do_cfg(8'b00000011, 4'd2, 8'd0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfgstart_busy got %b exp 1", busy); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (detected !== (i >= 1)) begin
                errors++; $display("FAIL cfgstart_detected bit %0d got %b exp %b", i + 1, detected, (i >= 1));
            end
        end
        checks++; if (hit_count !== 8'd2) begin errors++; $display("FAIL cfgstart_hit_count got %0d exp 2", hit_count); end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_len_clamp;
        logic [3:0] seq = 4'b0101;
        logic [7:0] pat = 8'hA5;
        do_cfg(8'h01, 4'd0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(seq[3-i], 1'b0, 1'b0);
            checks++;
            if (detected !== ((i == 1) || (i == 3))) begin
                errors++; $display("FAIL len0_detected bit %0d got %b exp %b", i + 1, detected, ((i == 1) || (i == 3)));
            end
        end
        step(1'b0, 1'b1, 1'b0);
        do_cfg(8'hA5, 4'd15, 8'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(pat[7-i], 1'b0, 1'b0);
            checks++;
            if (detected !== (i == 7)) begin
                errors++; $display("FAIL len15_detected bit %0d got %b exp %b", i + 1, detected, (i == 7));
            end
        end
        checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL len15_hit_count got %0d exp 1", hit_count); end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midrun;
        do_cfg(8'b00000001, 4'd2, 8'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (detected !== 1'b1) begin errors++; $display("FAIL mid_pre_detected got %b exp 1", detected); end
        rst = 1'b1;
        #1;
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL mid_rst_detected got %b exp 0", detected); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL mid_rst_hit_count got %0d exp 0", hit_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cfg_ready got %b exp 1", cfg_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (detected !== (i >= 7)) begin
                errors++; $display("FAIL mid_rearm_detected bit %0d got %b exp %b", i + 1, detected, (i >= 7));
            end
        end
        checks++; if (hit_count !== 8'd2) begin errors++; $display("FAIL mid_rearm_hit_count got %0d exp 2", hit_count); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_threshold();
        test_stop_race();
        test_cfg_with_start();
        test_len_clamp();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
